// File: rtl/gpc_axil_arbiter_if.sv
`timescale 1ns/1ps
// gpc_axil_arbiter_if
// One AXI-Lite link: AR, R, AW, W and B channels.
//   master modport : drives requests (ar*/aw*/w*, rready, bready) and
//                    receives readies and responses.
//   slave modport  : the opposite direction.
// Parameters: ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH (= DATA_WIDTH/8).
interface gpc_axil_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready
    );

    modport slave (
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready
    );
endinterface

// File: rtl/gpc_axil_arbiter.sv
`timescale 1ns/1ps
// gpc_axil_arbiter
// Shares one AXI-Lite slave (the GPC register bridge) between two masters:
// s0_axil (host CPU) and s1_axil (frame sequencer). Read and write paths
// are arbitrated independently, each with one outstanding transaction; a
// grant is held until that transaction's response handshake completes.
//
// Build option: define GPC_AXIL_ARB_RR_EN for round-robin arbitration with
// separate read/write "last granted" pointers (reset to 1 so master 0 wins
// first). Without it, master 0 always wins simultaneous requests.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   s0_axil       slave modport, master 0 side
//   s1_axil       slave modport, master 1 side
//   m_axil        master modport, towards the bridge
//   rd_state_o    read FSM state  (0 idle, 1 addr, 2 resp)
//   wr_state_o    write FSM state (0 idle, 1 xfer, 2 resp)
//   rd_gnt_o      current read grant (master index)
//   wr_gnt_o      current write grant (master index)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Valid never waits on ready. Ready/valid seen by a master
// are combinational pass-throughs of the bridge's, gated by grant and state,
// so upstream logic must not feed them back into its own valid.
module gpc_axil_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                clk,
    input  logic                rst,
    gpc_axil_arbiter_if.slave   s0_axil,
    gpc_axil_arbiter_if.slave   s1_axil,
    gpc_axil_arbiter_if.master  m_axil,
    output logic [1:0]          rd_state_o,
    output logic [1:0]          wr_state_o,
    output logic                rd_gnt_o,
    output logic                wr_gnt_o
);

    typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_RESP = 2'd2} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_XFER = 2'd1, WR_RESP = 2'd2} wr_state_e;

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    logic      rgnt_q, rgnt_d;
    logic      wgnt_q, wgnt_d;
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;

    // Granted master's request/accept signals.
    logic rsel_arvalid, rsel_rready;
    logic wsel_awvalid, wsel_wvalid, wsel_bready;
    logic rd_ar_hs, rd_r_hs, wr_aw_hs, wr_w_hs, wr_b_hs;
    logic rd_pick, wr_pick;

    logic [ADDR_WIDTH-1:0] ar_addr_mux, aw_addr_mux;
    logic [DATA_WIDTH-1:0] w_data_mux;
    logic [STRB_WIDTH-1:0] w_strb_mux;

    assign rsel_arvalid = rgnt_q ? s1_axil.arvalid : s0_axil.arvalid;
    assign rsel_rready  = rgnt_q ? s1_axil.rready  : s0_axil.rready;
    assign wsel_awvalid = wgnt_q ? s1_axil.awvalid : s0_axil.awvalid;
    assign wsel_wvalid  = wgnt_q ? s1_axil.wvalid  : s0_axil.wvalid;
    assign wsel_bready  = wgnt_q ? s1_axil.bready  : s0_axil.bready;

    assign ar_addr_mux = rgnt_q ? s1_axil.araddr : s0_axil.araddr;
    assign aw_addr_mux = wgnt_q ? s1_axil.awaddr : s0_axil.awaddr;
    assign w_data_mux  = wgnt_q ? s1_axil.wdata  : s0_axil.wdata;
    assign w_strb_mux  = wgnt_q ? s1_axil.wstrb  : s0_axil.wstrb;

    // Handshakes as seen on the bridge side; AW/W are masked once done.
    assign rd_ar_hs = (rd_state_q == RD_ADDR) && rsel_arvalid && m_axil.arready;
    assign rd_r_hs  = (rd_state_q == RD_RESP) && rsel_rready && m_axil.rvalid;
    assign wr_aw_hs = (wr_state_q == WR_XFER) && !aw_done_q && wsel_awvalid && m_axil.awready;
    assign wr_w_hs  = (wr_state_q == WR_XFER) && !w_done_q && wsel_wvalid && m_axil.wready;
    assign wr_b_hs  = (wr_state_q == WR_RESP) && wsel_bready && m_axil.bvalid;

`ifdef GPC_AXIL_ARB_RR_EN
    // Pointers hold the last granted master; on a tie the other one wins.
    logic rptr_q, rptr_d, wptr_q, wptr_d;

    assign rd_pick = (s0_axil.arvalid && s1_axil.arvalid) ? !rptr_q : s1_axil.arvalid;
    assign wr_pick = (s0_axil.awvalid && s1_axil.awvalid) ? !wptr_q : s1_axil.awvalid;
    assign rptr_d  = rd_r_hs ? rgnt_q : rptr_q;
    assign wptr_d  = wr_b_hs ? wgnt_q : wptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q <= 1'b1;
            wptr_q <= 1'b1;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end
`else
    // Fixed priority: master 1 only wins when master 0 is not requesting.
    assign rd_pick = s1_axil.arvalid && !s0_axil.arvalid;
    assign wr_pick = s1_axil.awvalid && !s0_axil.awvalid;
`endif

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            rgnt_q     <= 1'b0;
            wgnt_q     <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rgnt_q     <= rgnt_d;
            wgnt_q     <= wgnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Read next state.
    always_comb begin
        rd_state_d = rd_state_q;
        rgnt_d     = rgnt_q;
        case (rd_state_q)
            RD_IDLE: if (s0_axil.arvalid || s1_axil.arvalid) begin
                rgnt_d     = rd_pick;
                rd_state_d = RD_ADDR;
            end
            RD_ADDR: if (rd_ar_hs) rd_state_d = RD_RESP;
            RD_RESP: if (rd_r_hs)  rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Write next state. AW and W finish in either order; both must be done.
    always_comb begin
        wr_state_d = wr_state_q;
        wgnt_d     = wgnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            WR_IDLE: if (s0_axil.awvalid || s1_axil.awvalid) begin
                wgnt_d     = wr_pick;
                wr_state_d = WR_XFER;
            end
            WR_XFER: begin
                aw_done_d = aw_done_q || wr_aw_hs;
                w_done_d  = w_done_q || wr_w_hs;
                if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
            end
            WR_RESP: if (wr_b_hs) begin
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
                wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Outputs.
    always_comb begin
        m_axil.araddr   = ar_addr_mux;
        m_axil.arprot   = rgnt_q ? s1_axil.arprot : s0_axil.arprot;
        m_axil.arvalid  = (rd_state_q == RD_ADDR) && rsel_arvalid;
        m_axil.rready   = (rd_state_q == RD_RESP) && rsel_rready;
        m_axil.awaddr   = aw_addr_mux;
        m_axil.awprot   = wgnt_q ? s1_axil.awprot : s0_axil.awprot;
        m_axil.awvalid  = (wr_state_q == WR_XFER) && !aw_done_q && wsel_awvalid;
        m_axil.wdata    = w_data_mux;
        m_axil.wstrb    = w_strb_mux;
        m_axil.wvalid   = (wr_state_q == WR_XFER) && !w_done_q && wsel_wvalid;
        m_axil.bready   = (wr_state_q == WR_RESP) && wsel_bready;

        s0_axil.arready = (rd_state_q == RD_ADDR) && !rgnt_q && m_axil.arready;
        s1_axil.arready = (rd_state_q == RD_ADDR) &&  rgnt_q && m_axil.arready;
        s0_axil.rvalid  = (rd_state_q == RD_RESP) && !rgnt_q && m_axil.rvalid;
        s1_axil.rvalid  = (rd_state_q == RD_RESP) &&  rgnt_q && m_axil.rvalid;
        s0_axil.awready = (wr_state_q == WR_XFER) && !wgnt_q && !aw_done_q && m_axil.awready;
        s1_axil.awready = (wr_state_q == WR_XFER) &&  wgnt_q && !aw_done_q && m_axil.awready;
        s0_axil.wready  = (wr_state_q == WR_XFER) && !wgnt_q && !w_done_q && m_axil.wready;
        s1_axil.wready  = (wr_state_q == WR_XFER) &&  wgnt_q && !w_done_q && m_axil.wready;
        s0_axil.bvalid  = (wr_state_q == WR_RESP) && !wgnt_q && m_axil.bvalid;
        s1_axil.bvalid  = (wr_state_q == WR_RESP) &&  wgnt_q && m_axil.bvalid;

        // Response payloads are broadcast; only the valid is steered.
        s0_axil.rdata   = m_axil.rdata;
        s1_axil.rdata   = m_axil.rdata;
        s0_axil.rresp   = m_axil.rresp;
        s1_axil.rresp   = m_axil.rresp;
        s0_axil.bresp   = m_axil.bresp;
        s1_axil.bresp   = m_axil.bresp;
    end

    assign rd_state_o = rd_state_q;
    assign wr_state_o = wr_state_q;
    assign rd_gnt_o   = rgnt_q;
    assign wr_gnt_o   = wgnt_q;

endmodule

// File: tb/tb_gpc_axil_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for gpc_axil_arbiter with a zero-wait bridge model.
module tb_gpc_axil_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] rd_state, wr_state;
    logic       rd_gnt, wr_gnt;

    int checks = 0;
    int errors = 0;

    gpc_axil_arbiter_if s0_if ();
    gpc_axil_arbiter_if s1_if ();
    gpc_axil_arbiter_if m_if ();

    gpc_axil_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .s0_axil    (s0_if),
        .s1_axil    (s1_if),
        .m_axil     (m_if),
        .rd_state_o (rd_state),
        .wr_state_o (wr_state),
        .rd_gnt_o   (rd_gnt),
        .wr_gnt_o   (wr_gnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bridge model ----------------
    logic       aw_seen, w_seen;
    int         aw_cnt, w_cnt;

    function automatic logic [63:0] data_of(input logic [63:0] a);
        return 64'hDEAD_BEEF ^ (a ^ 64'h8);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_if.rvalid <= 1'b0;
            m_if.rdata  <= '0;
            m_if.rresp  <= 2'b00;
            m_if.bvalid <= 1'b0;
            m_if.bresp  <= 2'b00;
            aw_seen     <= 1'b0;
            w_seen      <= 1'b0;
            aw_cnt      <= 0;
            w_cnt       <= 0;
        end else begin
            if (m_if.rvalid && m_if.rready) m_if.rvalid <= 1'b0;
            if (m_if.arvalid && m_if.arready) begin
                m_if.rvalid <= 1'b1;
                m_if.rdata  <= data_of(m_if.araddr);
            end
            if (m_if.bvalid && m_if.bready) m_if.bvalid <= 1'b0;
            if (m_if.awvalid && m_if.awready) begin
                aw_seen <= 1'b1;
                aw_cnt  <= aw_cnt + 1;
            end
            if (m_if.wvalid && m_if.wready) begin
                w_seen <= 1'b1;
                w_cnt  <= w_cnt + 1;
            end
            if ((aw_seen || (m_if.awvalid && m_if.awready)) &&
                (w_seen || (m_if.wvalid && m_if.wready))) begin
                m_if.bvalid <= 1'b1;
                m_if.bresp  <= 2'b00;
                aw_seen     <= 1'b0;
                w_seen      <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [64:0] rd_exp_q[$];   // {master, rdata}
    logic [2:0]  wr_exp_q[$];   // {master, bresp}

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_pop(input logic id, input logic [63:0] data);
        logic [64:0] e;
        if (rd_exp_q.size() == 0) begin
            check("rd_unexpected", {id, data}, 65'h0);
        end else begin
            e = rd_exp_q.pop_front();
            check("rd_resp", {id, data}, e);
        end
    endtask

    task automatic wr_pop(input logic id, input logic [1:0] resp);
        logic [2:0] e;
        if (wr_exp_q.size() == 0) begin
            check("wr_unexpected", {id, resp}, 3'h0);
        end else begin
            e = wr_exp_q.pop_front();
            check("wr_resp", {id, resp}, e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (s0_if.rvalid && s0_if.rready) rd_pop(1'b0, s0_if.rdata);
            if (s1_if.rvalid && s1_if.rready) rd_pop(1'b1, s1_if.rdata);
            if (s0_if.bvalid && s0_if.bready) wr_pop(1'b0, s0_if.bresp);
            if (s1_if.bvalid && s1_if.bready) wr_pop(1'b1, s1_if.bresp);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] outs_vec();
        return {m_if.arvalid, m_if.rready, m_if.awvalid, m_if.wvalid, m_if.bready,
                s0_if.arready, s0_if.rvalid, s0_if.awready, s0_if.wready, s0_if.bvalid,
                s1_if.arready, s1_if.rvalid, s1_if.awready, s1_if.wready, s1_if.bvalid};
    endfunction

    task automatic do_read(input logic id, input logic [63:0] a);
        int n;
        if (id) begin s1_if.araddr = a; s1_if.arvalid = 1'b1; end
        else    begin s0_if.araddr = a; s0_if.arvalid = 1'b1; end
        n = 0;
        while (!(id ? s1_if.arready : s0_if.arready) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) check("ar_timeout", 1, 0);
        tick();
        if (id) s1_if.arvalid = 1'b0;
        else    s0_if.arvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd_exp_q.size() != 0 || wr_exp_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check("drain", rd_exp_q.size() + wr_exp_q.size(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        s0_if.araddr = '0; s0_if.arprot = '0; s0_if.arvalid = 0; s0_if.rready = 1;
        s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awvalid = 0;
        s0_if.wdata  = '0; s0_if.wstrb  = '0; s0_if.wvalid  = 0; s0_if.bready = 1;
        s1_if.araddr = '0; s1_if.arprot = '0; s1_if.arvalid = 0; s1_if.rready = 1;
        s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.awvalid = 0;
        s1_if.wdata  = '0; s1_if.wstrb  = '0; s1_if.wvalid  = 0; s1_if.bready = 1;
        m_if.arready = 1; m_if.awready = 1; m_if.wready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Reset state.
        check("reset_outs", outs_vec(), 15'h0);
        check("reset_states", {rd_state, wr_state}, 4'h0);

        // Simultaneous reads, 4 per master, zero-wait bridge.
`ifdef GPC_AXIL_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            rd_exp_q.push_back({1'b0, data_of(64'h100 + 64'(k) * 8)});
            rd_exp_q.push_back({1'b1, data_of(64'h200 + 64'(k) * 8)});
        end
`else
        for (int k = 0; k < 4; k++) rd_exp_q.push_back({1'b0, data_of(64'h100 + 64'(k) * 8)});
        for (int k = 0; k < 4; k++) rd_exp_q.push_back({1'b1, data_of(64'h200 + 64'(k) * 8)});
`endif
        fork
            begin
                for (int k = 0; k < 4; k++) do_read(1'b0, 64'h100 + 64'(k) * 8);
            end
            begin
                for (int k = 0; k < 4; k++) do_read(1'b1, 64'h200 + 64'(k) * 8);
            end
        join
        drain();
        tick();

        // Single read from master 0.
        rd_exp_q.push_back({1'b0, 64'hDEAD_BEEF});
        s0_if.araddr = 64'h08; s0_if.arvalid = 1'b1;
        tick();
        check("single_m_arvalid", m_if.arvalid, 1'b1);
        check("single_m_araddr", m_if.araddr, 64'h08);
        check("single_rgnt", rd_gnt, 1'b0);
        tick();
        s0_if.arvalid = 1'b0;
        check("single_s0_rvalid", s0_if.rvalid, 1'b1);
        check("single_s0_rdata", s0_if.rdata, 64'hDEAD_BEEF);
        check("single_s1_rvalid", s1_if.rvalid, 1'b0);
        tick();
        check("single_back_idle", rd_state, 2'd0);
        drain();

        // Write on master 1 with W leading AW by 3 cycles; AW stalled once.
        m_if.awready = 1'b0;
        s1_if.wdata = 64'h1111_2222_3333_4444; s1_if.wstrb = 8'hFF; s1_if.wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("w_alone_no_req", {m_if.wvalid, s1_if.wready, wr_state}, 4'h0);
        end
        wr_exp_q.push_back({1'b1, 2'b00});
        s1_if.awaddr = 64'h40; s1_if.awvalid = 1'b1;
        tick();
        check("wr_xfer_valids", {m_if.awvalid, m_if.wvalid, wr_gnt}, 3'b111);
        check("wr_m_wdata", m_if.wdata, 64'h1111_2222_3333_4444);
        check("wr_m_awaddr", m_if.awaddr, 64'h40);
        tick();
        check("w_masked", {m_if.wvalid, s1_if.wready, m_if.awvalid}, 3'b001);
        m_if.awready = 1'b1;
        tick();
        s1_if.awvalid = 1'b0; s1_if.wvalid = 1'b0;
        check("wr_in_resp", wr_state, 2'd2);
        check("wr_hs_counts", {aw_cnt[7:0], w_cnt[7:0]}, 16'h0101);
        check("wr_s1_bvalid", {s1_if.bvalid, s0_if.bvalid}, 2'b10);
        drain();

        // Concurrent: s0 write and s1 read issued in the same cycle.
        rd_exp_q.push_back({1'b1, data_of(64'h90)});
        wr_exp_q.push_back({1'b0, 2'b00});
        s0_if.awaddr = 64'h80; s0_if.awvalid = 1'b1;
        s0_if.wdata = 64'h5555; s0_if.wstrb = 8'h0F; s0_if.wvalid = 1'b1;
        s1_if.araddr = 64'h90; s1_if.arvalid = 1'b1;
        tick();
        check("conc_m_valids", {m_if.awvalid, m_if.wvalid, m_if.arvalid}, 3'b111);
        check("conc_grants", {wr_gnt, rd_gnt}, 2'b01);
        tick();
        s0_if.awvalid = 1'b0; s0_if.wvalid = 1'b0; s1_if.arvalid = 1'b0;
        drain();

        // Backpressure: s0 holds rready low 10 cycles, s1 read pending.
        rd_exp_q.push_back({1'b0, data_of(64'h18)});
        rd_exp_q.push_back({1'b1, data_of(64'h28)});
        s0_if.rready = 1'b0;
        s0_if.araddr = 64'h18; s0_if.arvalid = 1'b1;
        tick();
        tick();
        s0_if.arvalid = 1'b0;
        s1_if.araddr = 64'h28; s1_if.arvalid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold", {m_if.rready, s1_if.arready, rd_gnt, rd_state}, 5'b00010);
        end
        s0_if.rready = 1'b1;
        tick();
        check("bp_idle_after_r", {rd_state, m_if.arvalid}, 3'b000);
        tick();
        check("bp_s1_granted", {m_if.arvalid, rd_gnt}, 2'b11);
        check("bp_s1_addr", m_if.araddr, 64'h28);
        tick();
        s1_if.arvalid = 1'b0;
        drain();

        // Reset pulsed while in WR_XFER (AW done, W never offered).
        s0_if.awaddr = 64'hA0; s0_if.awvalid = 1'b1;
        tick();
        tick();
        check("rst_in_xfer", {wr_state, m_if.awvalid}, 3'b010);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outs", outs_vec(), 15'h0);
        check("rst_async_states", {rd_state, wr_state}, 4'h0);
        s0_if.awvalid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wr_exp_q.push_back({1'b1, 2'b00});
        s1_if.awaddr = 64'hB0; s1_if.awvalid = 1'b1;
        s1_if.wdata = 64'h77; s1_if.wstrb = 8'h01; s1_if.wvalid = 1'b1;
        tick();
        check("post_rst_s1_gnt", {wr_gnt, m_if.awvalid, m_if.awaddr[7:0]}, 10'b11_1011_0000);
        tick();
        s1_if.awvalid = 1'b0; s1_if.wvalid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpc_axil_arbiter.md
# gpc_axil_arbiter

Two-master AXI-Lite arbiter that shares the single AXI-Lite slave port of the GPC AXI-Lite/AXI-Stream register bridge between a host CPU master (port 0) and an on-chip frame sequencer (port 1). Read and write channels are arbitrated independently. Each path allows one outstanding transaction, and a grant is held until that transaction's response handshake completes. It sits directly in front of the bridge's AXI-Lite slave interface.

## Interface
Parameters:
- ADDR_WIDTH, 64, AXI-Lite address width on all ports
- DATA_WIDTH, 64, AXI-Lite data width on all ports
- STRB_WIDTH, DATA_WIDTH/8, write strobe width

Ports (`s{0,1}` = one instance per master; `m` = to bridge):
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s{0,1}_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  read address from master
- s{0,1}_axil_arready  out  1  read address accept
- s{0,1}_axil_rdata/rresp/rvalid  out  DATA_WIDTH/2/1  read data to master
- s{0,1}_axil_rready  in  1  read data accept
- s{0,1}_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  write address from master
- s{0,1}_axil_awready  out  1  write address accept
- s{0,1}_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1  write data from master
- s{0,1}_axil_wready  out  1  write data accept
- s{0,1}_axil_bresp/bvalid  out  2/1  write response to master
- s{0,1}_axil_bready  in  1  write response accept
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH/3/1  read address to bridge
- m_axil_arready  in  1
- m_axil_rdata/rresp/rvalid  in  DATA_WIDTH/2/1
- m_axil_rready  out  1
- m_axil_awaddr/awprot/awvalid, wdata/wstrb/wvalid  out  as above
- m_axil_awready, wready  in  1
- m_axil_bresp/bvalid  in  2/1
- m_axil_bready  out  1

## Operation
- Read FSM: RD_IDLE -> RD_ADDR -> RD_RESP -> RD_IDLE.
  - RD_IDLE: if any s_i_arvalid, latch grant `rgnt`, go to RD_ADDR.
  - RD_ADDR: m_ar* mirror s_rgnt_ar*; s_rgnt_arready = m_arready. On the m AR handshake go to RD_RESP.
  - RD_RESP: s_rgnt_rvalid = m_rvalid; m_rready = s_rgnt_rready. On the R handshake, update the read pointer and go to RD_IDLE.
- Write FSM: WR_IDLE -> WR_XFER -> WR_RESP -> WR_IDLE.
  - Request is awvalid only; wvalid alone is not a request.
  - WR_XFER forwards AW and W of `wgnt` independently. Flags aw_done and w_done are set on the respective m handshake, and each channel's valid is masked once its flag is set. When both flags are set, go to WR_RESP.
  - WR_RESP routes B like R. On the B handshake, clear the flags, update the write pointer and go to WR_IDLE.
- Non-granted master sees arready/awready/wready/rvalid/bvalid = 0. rdata/rresp/bresp are broadcast to both masters from m.
- Arbitration: round-robin (see Configuration). Read and write pointers are separate. Both masters requesting in the same cycle: grant the master that was not granted last.
- A master's valid that rises while the other master is granted waits, stalled by ready = 0. It is never dropped.
- Data paths are combinational pass-through; only grant, state, flags and pointers are registered.

## Timing
- Reset: both FSMs idle, flags 0, pointers = 1 (master 0 wins first). All m valids, m readies and all s ready/valid outputs are 0 while idle.
- Arbitration latency: 1 cycle. arvalid sampled in RD_IDLE at cycle N gives m_arvalid high at N+1.
- Minimum read occupancy: AR at N+1, R at N+2, next grant at N+3. Write: AW and W at N+1, B at N+2, next grant at N+3.
- Response handshake cycle to next RD_ADDR/WR_XFER: 1 cycle (via IDLE).
- Combinational paths m_*ready -> s_*ready and m_*valid -> s_*valid exist. Upstream must not loop them back combinationally.
- Read and write paths may be granted to different masters in the same cycle.
- Reset asserted mid-transaction: FSMs go idle immediately and the outstanding transaction is abandoned. The bridge is reset on the same rst.

## Configuration
- GPC_AXIL_ARB_RR_EN defined: round-robin arbitration, with per-path pointers as above.
- Not defined: fixed priority, master 0 always wins simultaneous requests. Pointers are not built. Master 1 can starve under a back-to-back master-0 load.

## Test plan
- Single read: s0 araddr=0x08, slave returns rdata=0xDEAD_BEEF at N+2. Required: s0_rvalid with 0xDEAD_BEEF, s1_rvalid stays 0, m_araddr=0x08 at N+1.
- Simultaneous reads, both masters, 4 each, slave zero-wait:
  - RR_EN: grants alternate 0,1,0,1…
  - Without RR_EN: all master-0 reads complete before the first master-1 read.
- Write with W leading AW by 3 cycles on s1: m_wvalid drops after its handshake and is not repeated. Exactly one m AW and one m W handshake, then s1_bvalid with bresp=00.
- Concurrent paths: s0 write and s1 read issued in the same cycle. Required: both m_awvalid and m_arvalid high at N+1, completing independently.
- Backpressure: s0 holds rready=0 for 10 cycles. m_rready stays 0, a pending s1 read is not granted until the cycle after the s0 R handshake plus 1.
- rst pulsed while in WR_XFER: all outputs return to 0 asynchronously. A fresh s1 write after reset is granted first under RR_EN only if s0 is idle.
